// File: rtl/mem_dumper.sv
// Snapshots the flattened data-memory debug bus and streams it MSB-first, one byte per handshake.
// Define MEM_DUMPER_HEADER_EN to prefix the stream with an 0xA5 / word-count header.
module mem_dumper #(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int BYTE_SIZE     = 8
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_start,
  input  logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0] i_bus_debug,
  output logic [BYTE_SIZE-1:0]                      o_data,
  output logic                                      o_valid,
  input  logic                                      i_ready,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic [MEM_ADDR_SIZE-1:0]                  o_word_idx
);

  localparam int W   = 2**MEM_ADDR_SIZE;
  localparam int IMG = W*IO_BUS_SIZE;
  localparam int BPW = IO_BUS_SIZE/BYTE_SIZE;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [MEM_ADDR_SIZE-1:0] K_LAST = MEM_ADDR_SIZE'(W-1);
  localparam logic [BW-1:0]            B_LAST = BW'(BPW-1);
  localparam logic [MEM_ADDR_SIZE-1:0] K_ONE  = MEM_ADDR_SIZE'(1);
  localparam logic [BW-1:0]            B_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
`ifdef MEM_DUMPER_HEADER_EN
    ,
    HEADER
`endif
  } state_t;

  state_t                   state;
  logic [IMG-1:0]           shadow;
  logic [MEM_ADDR_SIZE-1:0] k;
  logic [BW-1:0]            b;
`ifdef MEM_DUMPER_HEADER_EN
  logic                     hdr_cnt;
`endif

  wire xfer = o_valid & i_ready;

  // Byte bb of word wk, counted from the word's most significant byte.
  function automatic logic [BYTE_SIZE-1:0] pick(
    input logic [IMG-1:0]           img,
    input logic [MEM_ADDR_SIZE-1:0] wk,
    input logic [BW-1:0]            bb
  );
    int base;
    base = int'(wk)*IO_BUS_SIZE + IO_BUS_SIZE
         - (int'(bb) + 1)*BYTE_SIZE;
    return img[base +: BYTE_SIZE];
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      shadow     <= '0;
      k          <= '0;
      b          <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_word_idx <= '0;
`ifdef MEM_DUMPER_HEADER_EN
      hdr_cnt    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          o_done     <= 1'b0;
          o_word_idx <= '0;
          if (i_start) begin
            shadow  <= i_bus_debug;
            k       <= '0;
            b       <= '0;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
`ifdef MEM_DUMPER_HEADER_EN
            hdr_cnt <= 1'b0;
            o_data  <= BYTE_SIZE'(8'hA5);
            state   <= HEADER;
`else
            o_data  <= pick(i_bus_debug, '0, '0);
            state   <= SEND;
`endif
          end
        end
`ifdef MEM_DUMPER_HEADER_EN
        HEADER: begin
          if (xfer) begin
            if (!hdr_cnt) begin
              hdr_cnt <= 1'b1;
              o_data  <= BYTE_SIZE'(W);
            end else begin
              o_data  <= pick(shadow, '0, '0);
              state   <= SEND;
            end
          end
        end
`endif
        SEND: begin
          o_word_idx <= k;
          if (xfer) begin
            if (b == B_LAST) begin
              b <= '0;
              if (k == K_LAST) begin
                o_valid    <= 1'b0;
                o_done     <= 1'b1;
                o_data     <= '0;
                o_word_idx <= '0;
                state      <= DONE;
              end else begin
                k          <= k + K_ONE;
                o_word_idx <= k + K_ONE;
                o_data     <= pick(shadow, k + K_ONE, '0);
              end
            end else begin
              b      <= b + B_ONE;
              o_data <= pick(shadow, k, b + B_ONE);
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          k      <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
